// File: rtl/normshift_if.sv
// -----------------------------------------------------------------------------
// normshift_if
// Handshake and data bundle for the iterative normalizing shifter.
//   Start / A / W64 / Flush : request side, driven by the client (master)
//   Ready / Busy / Done     : controller status, driven by the shifter (slave)
//   Y / Cnt / Zero          : normalized result, shift amount, zero-operand flag
// -----------------------------------------------------------------------------
interface normshift_if #(
  parameter int XLEN     = 64,
  parameter int LOG_XLEN = 6
);
  logic                Start;
  logic [XLEN-1:0]     A;
  logic                W64;
  logic                Flush;
  logic                Ready;
  logic                Busy;
  logic                Done;
  logic [XLEN-1:0]     Y;
  logic [LOG_XLEN:0]   Cnt;
  logic                Zero;

  modport master (
    output Start, A, W64, Flush,
    input  Ready, Busy, Done, Y, Cnt, Zero
  );

  modport slave (
    input  Start, A, W64, Flush,
    output Ready, Busy, Done, Y, Cnt, Zero
  );
endinterface

// File: rtl/normshift_seq.sv
// -----------------------------------------------------------------------------
// normshift_seq
// Iterative normalizing left shifter: shifts the operand left until its most
// significant 1 reaches the MSB and reports the shift amount (leading-zero
// count). Up to STEP bit positions are consumed per cycle, so latency depends
// on the operand.
// Ports:
//   clk      : clock
//   reset_n  : asynchronous active-low reset
//   bus      : normshift_if slave (Start/A/W64/Flush in, Ready/Busy/Done/Y/
//              Cnt/Zero out)
// -----------------------------------------------------------------------------
module normshift_seq #(
  parameter int XLEN     = 64,
  parameter int LOG_XLEN = 6,
  parameter int STEP     = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  normshift_if.slave  bus
);
  localparam int CW   = LOG_XLEN + 1;
  localparam int HALF = 32;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   r_q, r_d;
  logic [CW-1:0]     cnt_q, cnt_d;        // running shift count
  logic [CW-1:0]     cnt_out_q, cnt_out_d;
  logic [XLEN-1:0]   y_q, y_d;
  logic              zero_q, zero_d;
  logic              w64_q, w64_d;

  logic              w64_in;
  logic [STEP-1:0]   top_bits;
  logic [CW-1:0]     top_lz;
  logic [XLEN-1:0]   r_fin;
  logic [CW-1:0]     cnt_fin;

  // Leading-zero count of the top window; only used when the window is nonzero,
  // so the result is always 0..STEP-1.
  function automatic logic [CW-1:0] lzc_window(input logic [STEP-1:0] v);
    logic [CW-1:0] n;
    logic          found;
    n     = '0;
    found = 1'b0;
    for (int i = STEP - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + CW'(1);
      end
    end
    return n;
  endfunction

  // W-type only exists on a 64-bit datapath.
  assign w64_in   = (XLEN == 64) && bus.W64;
  assign top_bits = r_q[XLEN-1 -: STEP];
  assign top_lz   = lzc_window(top_bits);
  assign r_fin    = r_q << top_lz;
  assign cnt_fin  = cnt_q + top_lz;

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    cnt_d     = cnt_q;
    cnt_out_d = cnt_out_q;
    y_d       = y_q;
    zero_d    = zero_q;
    w64_d     = w64_q;

    if (bus.Flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.Start) begin
            // A 32-bit operand is parked in the upper half so the same MSB
            // window logic serves both widths.
            r_d     = w64_in ? (bus.A << HALF) : bus.A;
            cnt_d   = '0;
            zero_d  = 1'b0;
            w64_d   = w64_in;
            state_d = S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_q == '0) begin
            zero_d    = 1'b1;
            cnt_d     = w64_q ? CW'(HALF) : CW'(XLEN);
            cnt_out_d = w64_q ? CW'(HALF) : CW'(XLEN);
            y_d       = '0;
            state_d   = S_DONE;
          end else if (top_bits == '0) begin
            r_d   = r_q << STEP;
            cnt_d = cnt_q + CW'(STEP);
          end else begin
            // Result registers load on the final step so Y/Cnt are valid
            // in the same cycle Done is high.
            r_d       = r_fin;
            cnt_d     = cnt_fin;
            cnt_out_d = cnt_fin;
            y_d       = w64_q ? (r_fin >> HALF) : r_fin;
            state_d   = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      r_q       <= '0;
      cnt_q     <= '0;
      cnt_out_q <= '0;
      y_q       <= '0;
      zero_q    <= 1'b0;
      w64_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      cnt_q     <= cnt_d;
      cnt_out_q <= cnt_out_d;
      y_q       <= y_d;
      zero_q    <= zero_d;
      w64_q     <= w64_d;
    end
  end

  assign bus.Ready = (state_q == S_IDLE);
  assign bus.Busy  = (state_q == S_BUSY);
  assign bus.Done  = (state_q == S_DONE);
  assign bus.Y     = y_q;
  assign bus.Cnt   = cnt_out_q;
  assign bus.Zero  = zero_q;
endmodule

// File: tb/tb_normshift_seq.sv
// -----------------------------------------------------------------------------
// tb_normshift_seq
// Directed and random operations on normshift_seq (XLEN=64, STEP=8), checked
// against an arithmetic reference: leading-zero count by scanning from the MSB,
// normalized value = operand << lz within the active width, and
// latency = lz/STEP + 1.
// -----------------------------------------------------------------------------
module tb_normshift_seq;
  localparam int XLEN     = 64;
  localparam int LOG_XLEN = 6;
  localparam int STEP     = 8;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;

  // last completed result, used to confirm Flush leaves outputs alone
  logic [63:0] last_y;
  logic [6:0]  last_cnt;

  normshift_if #(.XLEN(XLEN), .LOG_XLEN(LOG_XLEN)) bus ();

  normshift_seq #(.XLEN(XLEN), .LOG_XLEN(LOG_XLEN), .STEP(STEP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: leading zeros of the operand within 32 or 64 bits.
  function automatic int ref_lz(input logic [63:0] a, input logic w);
    int width;
    int n;
    width = w ? 32 : 64;
    n = 0;
    while (n < width && a[width-1-n] == 1'b0) n++;
    return n;
  endfunction

  function automatic logic [63:0] ref_y(input logic [63:0] a, input logic w, input int lz);
    logic [31:0] lo;
    if (w) begin
      lo = a[31:0];
      lo = lo << lz;
      return {32'b0, lo};
    end
    return a << lz;
  endfunction

  // One complete operation; Start is held only for the accept cycle.
  task automatic run_op(input string tag, input logic [63:0] a, input logic w);
    int lz, lat, cycles, width;
    logic [63:0] ey;
    width = w ? 32 : 64;
    lz = ref_lz(a, w);
    ey = ref_y(a, w, lz);
    lat = (lz == width) ? 1 : (lz / STEP + 1);
    @(negedge clk);
    bus.Start = 1'b1; bus.A = a; bus.W64 = w;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    cycles = 0;
    while (!bus.Done && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    $display("op %s: A=%h W64=%0b -> Y=%h Cnt=%0d Zero=%0b after %0d cycles",
             tag, a, w, bus.Y, bus.Cnt, bus.Zero, cycles);
    check({tag, " latency"}, 64'(cycles), 64'(lat));
    check({tag, " Y"},       bus.Y, ey);
    check({tag, " Cnt"},     64'(bus.Cnt), 64'(lz));
    check({tag, " Zero"},    64'(bus.Zero), 64'(lz == width));
    @(posedge clk); #1;
    check({tag, " done width"}, 64'(bus.Done), 64'd0);
    check({tag, " ready"},      64'(bus.Ready), 64'd1);
    last_y = ey;
    last_cnt = 7'(lz);
  endtask

  initial begin
    int cyc;
    logic [63:0] ra;
    logic rw;
    n_cmp = 0; n_bad = 0;
    bus.Start = 1'b0; bus.A = '0; bus.W64 = 1'b0; bus.Flush = 1'b0;
    reset_n = 1'b0;
    #22;
    check("reset Ready", 64'(bus.Ready), 64'd1);
    check("reset Busy",  64'(bus.Busy),  64'd0);
    check("reset Done",  64'(bus.Done),  64'd0);
    check("reset Y",     bus.Y,          64'd0);
    check("reset Cnt",   64'(bus.Cnt),   64'd0);
    check("reset Zero",  64'(bus.Zero),  64'd0);
    @(negedge clk); reset_n = 1'b1;

    run_op("one",     64'h1, 1'b0);
    run_op("zero",    64'h0, 1'b0);
    run_op("zero_w",  64'hABCD_0000_0000_0000, 1'b1);
    run_op("msb",     64'h8000_0000_0000_0000, 1'b0);
    run_op("f0",      64'h0000_00F0_0000_0000, 1'b0);
    run_op("w_upper", 64'hFFFF_FFFF_0000_0001, 1'b1);
    run_op("w_msb",   64'h0000_0000_8000_0000, 1'b1);
    run_op("step_b",  64'h0080_0000_0000_0000, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ra = {$urandom, $urandom} >> $urandom_range(0, 64);
      rw = 1'($urandom_range(0, 1));
      run_op($sformatf("rnd%0d", i), ra, rw);
    end

    // Start while busy is ignored
    @(negedge clk);
    bus.Start = 1'b1; bus.A = 64'h1; bus.W64 = 1'b0;
    @(posedge clk); #1; bus.Start = 1'b0;
    @(posedge clk); @(negedge clk);
    bus.Start = 1'b1; bus.A = 64'h8000_0000_0000_0000;
    @(posedge clk); #1; bus.Start = 1'b0;
    cyc = 2;
    while (!bus.Done && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    $display("op busy_start: Y=%h Cnt=%0d after %0d cycles", bus.Y, bus.Cnt, cyc);
    check("busy_start latency", 64'(cyc), 64'd8);
    check("busy_start Cnt",     64'(bus.Cnt), 64'd63);
    check("busy_start Y",       bus.Y, 64'h8000_0000_0000_0000);
    last_y = 64'h8000_0000_0000_0000; last_cnt = 7'd63;
    @(posedge clk); #1;

    // Flush in BUSY cycle 3
    @(negedge clk);
    bus.Start = 1'b1; bus.A = 64'h1;
    @(posedge clk); #1; bus.Start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); bus.Flush = 1'b1;
    @(posedge clk); #1; bus.Flush = 1'b0;
    $display("op flush: Ready=%0b Done=%0b Y=%h Cnt=%0d", bus.Ready, bus.Done, bus.Y, bus.Cnt);
    check("flush Ready", 64'(bus.Ready), 64'd1);
    check("flush Done",  64'(bus.Done),  64'd0);
    check("flush Y",     bus.Y, last_y);
    check("flush Cnt",   64'(bus.Cnt), 64'(last_cnt));
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.Done) cyc++;
    end
    check("flush no Done", 64'(cyc), 64'd0);

    // Start and Flush together in IDLE
    @(negedge clk);
    bus.Start = 1'b1; bus.Flush = 1'b1; bus.A = 64'h1;
    @(posedge clk); #1;
    bus.Start = 1'b0; bus.Flush = 1'b0;
    $display("op start_flush: Ready=%0b Busy=%0b", bus.Ready, bus.Busy);
    check("start_flush Ready", 64'(bus.Ready), 64'd1);
    check("start_flush Busy",  64'(bus.Busy),  64'd0);
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.Done) cyc++;
    end
    check("start_flush no Done", 64'(cyc), 64'd0);

    // Asynchronous reset mid-operation
    @(negedge clk);
    bus.Start = 1'b1; bus.A = 64'h1;
    @(posedge clk); #1; bus.Start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    $display("op async_reset: Ready=%0b Busy=%0b Y=%h Cnt=%0d", bus.Ready, bus.Busy, bus.Y, bus.Cnt);
    check("areset Ready", 64'(bus.Ready), 64'd1);
    check("areset Busy",  64'(bus.Busy),  64'd0);
    check("areset Done",  64'(bus.Done),  64'd0);
    check("areset Y",     bus.Y, 64'd0);
    check("areset Cnt",   64'(bus.Cnt), 64'd0);
    check("areset Zero",  64'(bus.Zero), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.Done) cyc++;
    end
    check("areset no Done", 64'(cyc), 64'd0);
    run_op("post_reset", 64'h0000_0000_0001_0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/normshift_seq.md
Name: normshift_seq

Overview:
Iterative normalizing left shifter. It is the inverse companion of the IEU funnel shifter: given an operand, it derives the shift amount (leading-zero count) that places the most significant 1 at the MSB, and returns the normalized value. It serves the multi-cycle divider/normalization path and low-area clz-style configs. It uses a start/done handshake, is multi-cycle, and has variable latency.

Parameters:
XLEN, 64, datapath width; 32 or 64.
LOG_XLEN, 6, log2(XLEN).
STEP, 8, maximum shift per cycle; power of two; must divide 32.

Ports:
clk  in  1  clock.
reset_n  in  1  asynchronous active-low reset.
Start  in  1  request; accepted only when Ready=1.
A  in  XLEN  operand; sampled at the accept edge.
W64  in  1  RV64 W-type: normalize A[31:0] as a 32-bit value; ignored (treated as 0) when XLEN=32.
Flush  in  1  abort any operation; synchronous.
Ready  out  1  high in IDLE.
Busy  out  1  high in BUSY.
Done  out  1  one-cycle pulse when a result becomes valid.
Y  out  XLEN  normalized result.
Cnt  out  LOG_XLEN+1  leading-zero count / shift amount.
Zero  out  1  operand was zero.

Behaviour:
- Reset (async, reset_n=0): state IDLE, Ready=1, Busy=0, Done=0, Y=0, Cnt=0, Zero=0, and the internal working register R is cleared. Reset mid-operation discards the operation and no Done is produced.
- States: IDLE, BUSY, DONE.
- IDLE, Start=1, Flush=0 → accept.
  - R = W64 ? {A[31:0], 32'b0} : A.
  - Internal count = 0; Zero cleared.
  - Latch W64; go to BUSY.
- BUSY, evaluated in priority order each cycle:
  - R==0 → Zero=1, Cnt = W64 ? 32 : XLEN, go to DONE.
  - Else, if R[XLEN-1 -: STEP] == 0 → R <<= STEP, count += STEP, stay in BUSY.
  - Else → R <<= lzc(R[XLEN-1 -: STEP]) (0..STEP-1), count += that lzc, go to DONE.
- DONE:
  - Done=1 for exactly one cycle, then IDLE.
  - Y = W64 ? {32'b0, R[XLEN-1:32]} : R.
  - Y, Cnt and Zero hold their values until the next accept.
- Latency: Done is high floor(lz/STEP)+1 cycles after the accept edge, where lz is the leading-zero count within the 32- or XLEN-bit width. A zero operand takes 1 cycle.
- Start while BUSY or DONE is ignored; it is not queued.
- Flush=1 in any state → IDLE next cycle, no Done. Y, Cnt and Zero keep their prior values.
- Flush and Start in the same cycle: Flush wins; Start is not accepted.
- Cnt never exceeds XLEN. Count arithmetic is LOG_XLEN+1 bits wide and never wraps.

Test Plan:
- XLEN=64, A=64'h1, W64=0 → 7 full-STEP shifts plus a final lzc of 7. Cnt=63, Y=64'h8000_0000_0000_0000, Zero=0. Done pulses 8 cycles after accept, exactly 1 cycle wide, then Ready=1.
- A=0 → Zero=1, Cnt=64, Y=0, Done 1 cycle after accept. With W64=1 and A[31:0]=0 → Cnt=32, Zero=1.
- A=64'h8000_0000_0000_0000 → Cnt=0, Y unchanged, Done 1 cycle after accept.
- A=64'h0000_00F0_0000_0000 → Cnt=24, Y=64'hF000_0000_0000_0000, Done 4 cycles after accept.
- W64=1, A=64'hFFFF_FFFF_0000_0001 → the upper 32 bits are ignored. Cnt=31, Y=64'h0000_0000_8000_0000, Done 4 cycles after accept.
- Control events during an A=64'h1 operation:
  - Start pulsed with A=64'h8000_0000_0000_0000 in BUSY cycle 2 → ignored; the result is still Cnt=63.
  - Flush in BUSY cycle 3 → Ready=1 the next cycle, no Done, outputs held.
  - reset_n dropped mid-BUSY → all outputs go to reset values immediately, asynchronously.
  - Start and Flush together in IDLE → not accepted.
